vdp_reg_write_arbiter: RTL and testbench

Merges VDP register writes from the host CPU bus and from the copper into the single write port of the VDP register file. Copper writes pass through a small FIFO, so short copper write bursts are not stalled while a host write is being issued. The block sits directly downstream of the copper's register-write interface and upstream of the VDP register file. It issues at most one register write per cycle and arbitrates fairly when both sources are pending.

---
 rtl/vdp_reg_write_arbiter_if.sv | 48 ++++
 rtl/vdp_reg_write_arbiter.sv | 122 ++++++++++++
 tb/tb_vdp_reg_write_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vdp_reg_write_arbiter_if.sv
// vdp_reg_write_arbiter_if
// Bundles the host write request, the copper write stream and the merged
// register-file write port of the VDP register write arbiter.
//   host_*          : host CPU single-write request (host_ready = slot free)
//   copper_*        : copper write stream into the FIFO, plus FIFO flush
//   reg_write_*     : merged write port toward the VDP register file
//   fifo_level      : copper FIFO occupancy
//   copper_overflow : sticky flag, a copper write was dropped
// The arbiter connects through the slave modport; the driving side
// (host/copper/register file) uses the master modport.
interface vdp_reg_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  logic             host_write_en;
  logic [5:0]       host_address;
  logic [15:0]      host_data;
  logic             host_ready;

  logic             copper_write_en;
  logic [5:0]       copper_address;
  logic [15:0]      copper_data;
  logic             copper_ready;
  logic             copper_flush;

  logic             reg_write_en;
  logic [5:0]       reg_write_address;
  logic [15:0]      reg_write_data;
  logic [LVL_W-1:0] fifo_level;
  logic             copper_overflow;

  modport master (
    output host_write_en, host_address, host_data,
    output copper_write_en, copper_address, copper_data, copper_flush,
    input  host_ready, copper_ready,
    input  reg_write_en, reg_write_address, reg_write_data,
    input  fifo_level, copper_overflow
  );

  modport slave (
    input  host_write_en, host_address, host_data,
    input  copper_write_en, copper_address, copper_data, copper_flush,
    output host_ready, copper_ready,
    output reg_write_en, reg_write_address, reg_write_data,
    output fifo_level, copper_overflow
  );
endinterface

// File: rtl/vdp_reg_write_arbiter.sv
// vdp_reg_write_arbiter
// Merges host CPU register writes and copper register writes into the single
// VDP register file write port. Copper writes are buffered in a small FIFO;
// the host has a one-entry holding register. When both sources have a write
// ready, the source that was not granted last wins.
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset
//   bus   : vdp_reg_write_arbiter_if.slave (host, copper and register port)
module vdp_reg_write_arbiter #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  vdp_reg_write_arbiter_if.slave  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [0:0] SRC_HOST   = 1'b0;
  localparam logic [0:0] SRC_COPPER = 1'b1;

  logic [5:0]       fifo_addr [FIFO_DEPTH];
  logic [15:0]      fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;

  logic             pending;
  logic [5:0]       hold_addr;
  logic [15:0]      hold_data;

  logic [0:0]       last_grant;
  logic             overflow;
  logic             out_en;
  logic [5:0]       out_addr;
  logic [15:0]      out_data;

  logic             copper_ready_i;
  logic             fifo_valid;
  logic             grant_copper;
  logic             grant_host;
  logic             push;
  logic             drop;

  // Everything here is decoded from pre-edge state, so a full FIFO stays
  // not-ready in the cycle it pops, and a flush cannot cancel a grant
  // already selected from the current head.
  always_comb begin
    copper_ready_i = (level < LVL_W'(FIFO_DEPTH));
    fifo_valid     = (level != '0);
    grant_copper   = fifo_valid && (!pending || (last_grant == SRC_HOST));
    grant_host     = pending && !grant_copper;
    push           = bus.copper_write_en && copper_ready_i && !bus.copper_flush;
    drop           = bus.copper_write_en && !copper_ready_i;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.copper_address;
      fifo_data[wr_ptr] <= bus.copper_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      pending    <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      last_grant <= SRC_HOST;
      overflow   <= 1'b0;
      out_en     <= 1'b0;
      out_addr   <= '0;
      out_data   <= '0;
    end else begin
      if (drop) begin
        overflow <= 1'b1;
      end

      if (bus.copper_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        level  <= '0;
      end else begin
        wr_ptr <= wr_ptr + PTR_W'(push);
        rd_ptr <= rd_ptr + PTR_W'(grant_copper);
        level  <= level + LVL_W'(push) - LVL_W'(grant_copper);
      end

      // grant_host requires pending, so load and clear never coincide.
      if (grant_host) begin
        pending <= 1'b0;
      end else if (bus.host_write_en && !pending) begin
        pending   <= 1'b1;
        hold_addr <= bus.host_address;
        hold_data <= bus.host_data;
      end

      out_en <= grant_copper || grant_host;
      if (grant_copper) begin
        out_addr   <= fifo_addr[rd_ptr];
        out_data   <= fifo_data[rd_ptr];
        last_grant <= SRC_COPPER;
      end else if (grant_host) begin
        out_addr   <= hold_addr;
        out_data   <= hold_data;
        last_grant <= SRC_HOST;
      end
    end
  end

  assign bus.host_ready        = !pending;
  assign bus.copper_ready      = copper_ready_i;
  assign bus.reg_write_en      = out_en;
  assign bus.reg_write_address = out_addr;
  assign bus.reg_write_data    = out_data;
  assign bus.fifo_level        = level;
  assign bus.copper_overflow   = overflow;
endmodule

// File: tb/tb_vdp_reg_write_arbiter.sv
// tb_vdp_reg_write_arbiter
// Directed vector table for single-write, contention, flush and reset cases,
// plus two streamed sequences (copper honouring ready / ignoring ready)
// checked against hand-derived grant orders.
module tb_vdp_reg_write_arbiter;
  logic clk;
  logic reset;

  vdp_reg_write_arbiter_if #(.FIFO_DEPTH(4)) bus ();

  vdp_reg_write_arbiter #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic        rst;
    logic        hen;
    logic [5:0]  ha;
    logic [15:0] hd;
    logic        cen;
    logic [5:0]  ca;
    logic [15:0] cd;
    logic        fl;
    logic        e_en;
    logic [5:0]  e_a;
    logic [15:0] e_d;
    logic [2:0]  e_lvl;
    logic        e_hr;
    logic        e_cr;
    logic        e_ov;
  } vec_t;

  vec_t vecs [30];

  task automatic drive_idle();
    bus.host_write_en   = 1'b0;
    bus.host_address    = 6'h00;
    bus.host_data       = 16'h0000;
    bus.copper_write_en = 1'b0;
    bus.copper_address  = 6'h00;
    bus.copper_data     = 16'h0000;
    bus.copper_flush    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [5:0]  iss_a [$];
  logic [15:0] iss_d [$];
  int          max_level;
  int          ready_bad;

  // Host re-submits whenever its slot is free (up to 7 writes, addr j,
  // data 4000+j); copper attempts n_cop writes (addr 20+i, data C000+i),
  // either waiting for copper_ready or ignoring it.
  task automatic run_stream(input bit honour, input int n_cop, output int cycles);
    int cpush;
    int hcnt;
    int idle;
    cpush = 0;
    hcnt = 0;
    idle = 0;
    cycles = 0;
    iss_a.delete();
    iss_d.delete();
    max_level = 0;
    ready_bad = 0;
    do_reset();
    while (cycles < 300 && idle < 6) begin
      @(negedge clk);
      if (int'(bus.fifo_level) > max_level) max_level = int'(bus.fifo_level);
      if (bus.copper_ready !== (bus.fifo_level < 3'd4)) ready_bad++;
      if (bus.host_ready && hcnt < 7) begin
        bus.host_write_en = 1'b1;
        bus.host_address  = 6'(hcnt);
        bus.host_data     = 16'h4000 + 16'(hcnt);
        hcnt++;
      end else begin
        bus.host_write_en = 1'b0;
      end
      if (cpush < n_cop && (!honour || bus.copper_ready)) begin
        bus.copper_write_en = 1'b1;
        bus.copper_address  = 6'h20 + 6'(cpush);
        bus.copper_data     = 16'hC000 + 16'(cpush);
        cpush++;
      end else begin
        bus.copper_write_en = 1'b0;
      end
      @(posedge clk);
      #1;
      if (bus.reg_write_en) begin
        iss_a.push_back(bus.reg_write_address);
        iss_d.push_back(bus.reg_write_data);
        idle = 0;
      end else if (cpush >= n_cop && hcnt >= 7) begin
        idle++;
      end
      cycles++;
    end
    @(negedge clk);
    drive_idle();
  endtask

  // Expected order is strict alternation starting with copper:
  // C0 H0 C1 H1 ... H6 C<last>, copper entries taken from cop_idx.
  task automatic check_order(input string tag, input int cop_idx [8]);
    check($sformatf("%s_count", tag), 32'(iss_a.size()), 32'd15);
    for (int k = 0; k < 15; k++) begin
      logic [5:0]  ea;
      logic [15:0] ed;
      if (k % 2 == 0) begin
        ea = 6'h20 + 6'(cop_idx[k/2]);
        ed = 16'hC000 + 16'(cop_idx[k/2]);
      end else begin
        ea = 6'((k - 1) / 2);
        ed = 16'h4000 + 16'((k - 1) / 2);
      end
      if (k < iss_a.size()) begin
        check($sformatf("%s_g%0d_addr", tag, k), 32'(iss_a[k]), 32'(ea));
        check($sformatf("%s_g%0d_data", tag, k), 32'(iss_d[k]), 32'(ed));
      end else begin
        check($sformatf("%s_g%0d_missing", tag, k), 32'(iss_a.size()), 32'(k + 1));
      end
    end
  endtask

  initial begin
    int cyc;
    int order_c [8];
    int order_d [8];

    reset = 1'b1;
    drive_idle();

    //        rst   hen   ha     hd        cen   ca     cd        fl     en    a      d         lvl   hr    cr    ov
    vecs[0]  = '{1'b1, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b1, 6'h05, 16'hBEEF, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd1, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 6'h05, 16'hBEEF, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h05, 16'hBEEF, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 6'h10, 16'h1234, 1'b1, 6'h11, 16'h5678, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 6'h11, 16'h5678, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 6'h10, 16'h1234, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h10, 16'h1234, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 6'h20, 16'hAAAA, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h10, 16'h1234, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 6'h20, 16'hAAAA, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 6'h21, 16'h1111, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h20, 16'hAAAA, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 6'h22, 16'h2222, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 6'h21, 16'h1111, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h21, 16'h1111, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 6'h01, 16'h1001, 1'b1, 6'h31, 16'h3101, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b1, 6'h32, 16'h3202, 1'b0, 1'b1, 6'h31, 16'h3101, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b1, 6'h33, 16'h3303, 1'b0, 1'b1, 6'h01, 16'h1001, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 6'h02, 16'h1002, 1'b1, 6'h34, 16'h3404, 1'b0, 1'b1, 6'h32, 16'h3202, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[19] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b1, 6'h35, 16'h3505, 1'b0, 1'b1, 6'h02, 16'h1002, 3'd3, 1'b1, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 6'h03, 16'h1003, 1'b1, 6'h36, 16'h3606, 1'b1, 1'b1, 6'h33, 16'h3303, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b1, 6'h03, 16'h1003, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h03, 16'h1003, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[23] = '{1'b1, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 6'h04, 16'h1004, 1'b1, 6'h37, 16'h3707, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[25] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b1, 6'h38, 16'h3808, 1'b0, 1'b1, 6'h37, 16'h3707, 3'd1, 1'b0, 1'b1, 1'b0};
    vecs[26] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b1, 6'h39, 16'h3909, 1'b0, 1'b1, 6'h04, 16'h1004, 3'd2, 1'b1, 1'b1, 1'b0};
    vecs[27] = '{1'b0, 1'b1, 6'h05, 16'h1005, 1'b1, 6'h3A, 16'h3A0A, 1'b0, 1'b1, 6'h38, 16'h3808, 3'd2, 1'b0, 1'b1, 1'b0};
    vecs[28] = '{1'b1, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0};
    vecs[29] = '{1'b0, 1'b0, 6'h00, 16'h0000, 1'b0, 6'h00, 16'h0000, 1'b0, 1'b0, 6'h00, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0};

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      reset               = vecs[i].rst;
      bus.host_write_en   = vecs[i].hen;
      bus.host_address    = vecs[i].ha;
      bus.host_data       = vecs[i].hd;
      bus.copper_write_en = vecs[i].cen;
      bus.copper_address  = vecs[i].ca;
      bus.copper_data     = vecs[i].cd;
      bus.copper_flush    = vecs[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_en", i),    32'(bus.reg_write_en),      32'(vecs[i].e_en));
      check($sformatf("row%0d_addr", i),  32'(bus.reg_write_address), 32'(vecs[i].e_a));
      check($sformatf("row%0d_data", i),  32'(bus.reg_write_data),    32'(vecs[i].e_d));
      check($sformatf("row%0d_level", i), 32'(bus.fifo_level),        32'(vecs[i].e_lvl));
      check($sformatf("row%0d_hready", i), 32'(bus.host_ready),       32'(vecs[i].e_hr));
      check($sformatf("row%0d_cready", i), 32'(bus.copper_ready),     32'(vecs[i].e_cr));
      check($sformatf("row%0d_ovf", i),   32'(bus.copper_overflow),   32'(vecs[i].e_ov));
    end
    @(negedge clk);
    reset = 1'b0;
    drive_idle();

    // Copper honours ready: 8 writes, host always pending.
    order_c = '{0, 1, 2, 3, 4, 5, 6, 7};
    run_stream(1'b1, 8, cyc);
    check("strmC_in_budget", 32'(cyc < 300), 32'd1);
    check_order("strmC", order_c);
    check("strmC_max_level", 32'(max_level), 32'd4);
    check("strmC_ready_decode", 32'(ready_bad), 32'd0);
    check("strmC_ovf", 32'(bus.copper_overflow), 32'd0);

    // Copper ignores ready: attempts 7 and 9 land on a full FIFO and drop.
    order_d = '{0, 1, 2, 3, 4, 5, 6, 8};
    run_stream(1'b0, 10, cyc);
    check("strmD_in_budget", 32'(cyc < 300), 32'd1);
    check_order("strmD", order_d);
    check("strmD_ovf", 32'(bus.copper_overflow), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("strmD_ovf_sticky", 32'(bus.copper_overflow), 32'd1);
    do_reset();
    #1;
    check("strmD_ovf_reset", 32'(bus.copper_overflow), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
